reveal_scheduler: RTL

Sequences the parallel reveal batch produced by the game engine after each stab (up to nine opened cells, each a board position plus neighbour-mine count) onto a single valid/ready stream for the display side. It sits between the play engine and the display/output logic. It replaces free-running index counting with a handshaked, back-pressurable drain. It buffers one additional batch so that a stab completing mid-drain is not lost, and reports busy/overflow to the input controller.

---
 rtl/reveal_scheduler_if.sv | 28 ++
 rtl/reveal_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/reveal_scheduler_if.sv
// Batch-in / entry-out signal bundle between the play engine, the reveal
// scheduler and the display side.
interface reveal_scheduler_if #(
  parameter int POS_W  = 6,
  parameter int MINE_W = 4
);
  logic                  done;
  logic [1:0]            select;
  logic [9*POS_W-1:0]    pos_bus;
  logic [9*MINE_W-1:0]   mine_bus;
  logic                  ready;
  logic                  valid;
  logic [POS_W-1:0]      position;
  logic [MINE_W-1:0]     mine;
  logic                  last;
  logic                  busy;
  logic                  overflow;

  modport master (
    output done, select, pos_bus, mine_bus, ready,
    input  valid, position, mine, last, busy, overflow
  );

  modport slave (
    input  done, select, pos_bus, mine_bus, ready,
    output valid, position, mine, last, busy, overflow
  );
endinterface

// File: rtl/reveal_scheduler.sv
// Drains a parallel reveal batch (1..9 cells) onto a valid/ready stream,
// holding one extra batch so a stab finishing mid-drain is not lost.
module reveal_scheduler #(
  parameter int POS_W  = 6,
  parameter int MINE_W = 4
) (
  input logic              clk,
  input logic              rst,
  reveal_scheduler_if.slave bus
);
  localparam int ENTRIES = 9;

  typedef enum logic {S_IDLE, S_STREAM} state_e;

  state_e              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [3:0]          act_n_q, act_n_d;
  logic [3:0]          pend_n_q, pend_n_d;
  logic                pend_full_q, pend_full_d;
  logic                overflow_q, overflow_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic [POS_W-1:0]    position_q, position_d;
  logic [MINE_W-1:0]   mine_q, mine_d;

  logic [POS_W-1:0]    act_pos_q  [ENTRIES], act_pos_d  [ENTRIES];
  logic [MINE_W-1:0]   act_mine_q [ENTRIES], act_mine_d [ENTRIES];
  logic [POS_W-1:0]    pend_pos_q [ENTRIES], pend_pos_d [ENTRIES];
  logic [MINE_W-1:0]   pend_mine_q[ENTRIES], pend_mine_d[ENTRIES];
  logic [POS_W-1:0]    in_pos     [ENTRIES];
  logic [MINE_W-1:0]   in_mine    [ENTRIES];
  logic [3:0]          in_n;

  logic                final_beat;
  logic                load_act_in, load_act_pend, store_pend;

  always_comb begin
    for (int k = 0; k < ENTRIES; k++) begin
      in_pos[k]  = bus.pos_bus[k*POS_W +: POS_W];
      in_mine[k] = bus.mine_bus[k*MINE_W +: MINE_W];
    end
    case (bus.select)
      2'b00:   in_n = 4'd4;
      2'b01:   in_n = 4'd6;
      2'b10:   in_n = 4'd9;
      default: in_n = 4'd1;
    endcase
  end

  assign final_beat = (idx_q == act_n_q - 4'd1);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d       = state_q;
    idx_d         = idx_q;
    act_n_d       = act_n_q;
    pend_n_d      = pend_n_q;
    pend_full_d   = pend_full_q;
    overflow_d    = overflow_q;
    act_pos_d     = act_pos_q;
    act_mine_d    = act_mine_q;
    pend_pos_d    = pend_pos_q;
    pend_mine_d   = pend_mine_q;
    load_act_in   = 1'b0;
    load_act_pend = 1'b0;
    store_pend    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.done) begin
          load_act_in = 1'b1;
          state_d     = S_STREAM;
        end
      end
      S_STREAM: begin
        if (bus.ready && final_beat) begin
          // Final beat: refill from pending first so the stream has no bubble.
          if (pend_full_q) begin
            load_act_pend = 1'b1;
            store_pend    = bus.done;
            pend_full_d   = bus.done;
          end else if (bus.done) begin
            load_act_in = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          if (bus.ready) idx_d = idx_q + 4'd1;
          if (bus.done) begin
            if (pend_full_q) begin
              overflow_d = 1'b1;
            end else begin
              store_pend  = 1'b1;
              pend_full_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_act_in) begin
      act_pos_d  = in_pos;
      act_mine_d = in_mine;
      act_n_d    = in_n;
      idx_d      = 4'd0;
    end
    if (load_act_pend) begin
      act_pos_d  = pend_pos_q;
      act_mine_d = pend_mine_q;
      act_n_d    = pend_n_q;
      idx_d      = 4'd0;
    end
    if (store_pend) begin
      pend_pos_d  = in_pos;
      pend_mine_d = in_mine;
      pend_n_d    = in_n;
    end

    valid_d    = (state_d == S_STREAM);
    position_d = valid_d ? act_pos_d[idx_d]  : '0;
    mine_d     = valid_d ? act_mine_d[idx_d] : '0;
    last_d     = valid_d && (idx_d == act_n_d - 4'd1);
    busy_d     = valid_d || pend_full_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      act_n_q     <= 4'd1;
      pend_n_q    <= 4'd1;
      pend_full_q <= 1'b0;
      overflow_q  <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      position_q  <= '0;
      mine_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      act_n_q     <= act_n_d;
      pend_n_q    <= pend_n_d;
      pend_full_q <= pend_full_d;
      overflow_q  <= overflow_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      position_q  <= position_d;
      mine_q      <= mine_d;
    end
  end

  // NOTE: entry storage is not reset; it is only read after a load, so reset would buy nothing.
  always_ff @(posedge clk) begin
    act_pos_q   <= act_pos_d;
    act_mine_q  <= act_mine_d;
    pend_pos_q  <= pend_pos_d;
    pend_mine_q <= pend_mine_d;
  end

  assign bus.valid    = valid_q;
  assign bus.position = position_q;
  assign bus.mine     = mine_q;
  assign bus.last     = last_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;
endmodule
